// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin output-channel arbiter.
// FSM encoding and transfer-counter width.
package mux_rr_arbiter_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Word selector shared by all requesters.
// Picks slot sel out of the packed data bus.
module mux_mod #(
  parameter int size = 8,
  parameter int n    = 3
) (
  input  logic [size*(2**n)-1:0] in,
  input  logic [n-1:0]           sel,
  output logic [size-1:0]        out
);

  assign out = in[int'(sel)*size +: size];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered output word
// among 2**n requesters with a valid/ready hand-off.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int size = 8,
  parameter int n    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [(2**n)-1:0]       req,
  input  logic [size*(2**n)-1:0]  in,
  output logic [(2**n)-1:0]       ack,
  output logic [size-1:0]         out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [n-1:0]            grant_idx,
  output logic [CNT_W-1:0]        xfer_count
);

  localparam int N = 2**n;

  arb_state_t state;
  logic [n-1:0] last;
  logic         xfer;
  logic [n-1:0] ptr;
  logic [N-1:0] mreq;
  logic         found;
  logic [n-1:0] cand;
  logic [size-1:0] word;

  assign xfer = (state == ARB_HOLD) && out_ready && !reset;

  // Completing transfer moves the pointer on the same edge,
  // so search from the slot being acked, with it masked out.
  assign ptr = xfer ? grant_idx : last;

  always_comb begin
    mreq = req;
    if (xfer) mreq[grant_idx] = 1'b0;
  end

  always_comb begin
    logic [n-1:0] j;
    found = 1'b0;
    cand  = '0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = ptr + n'(k);
      if (!found && mreq[j]) begin
        found = 1'b1;
        cand  = j;
      end
    end
  end

  mux_mod #(
    .size(size),
    .n   (n)
  ) u_mux (
    .in (in),
    .sel(cand),
    .out(word)
  );

  always_comb begin
    ack = '0;
    if (xfer) ack[grant_idx] = 1'b1;
  end

  assign out_valid = (state == ARB_HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      out        <= '0;
      grant_idx  <= '0;
      last       <= n'(N-1);
      xfer_count <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (found) begin
            out       <= word;
            grant_idx <= cand;
            state     <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          if (out_ready) begin
            last       <= grant_idx;
            xfer_count <= xfer_count + CNT_W'(1);
            if (found) begin
              out       <= word;
              grant_idx <= cand;
            end else begin
              state <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomised bench for mux_rr_arbiter with a queue-free
// behavioural model and literal checks of directed scenarios.
module tb_mux_rr_arbiter;

  localparam int SZ = 8;
  localparam int NB = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [SZ*NR-1:0] in;
  logic [NR-1:0] ack;
  logic [SZ-1:0] out;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] grant_idx;
  logic [15:0]   xfer_count;

  mux_rr_arbiter #(.size(SZ), .n(NB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in        (in),
    .ack       (ack),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_idx (grant_idx),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  bit      m_init = 0;
  bit      m_valid;
  int      m_out, m_idx, m_last, m_cnt;

  int c_out, c_valid, c_idx, c_cnt, c_ack;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] r, input int from);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (from + k) % NR;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic int slot(input logic [SZ*NR-1:0] d, input int i);
    return int'(d[i*SZ +: SZ]);
  endfunction

  task automatic model_edge(input logic rs, input logic [NR-1:0] rq,
                            input logic [SZ*NR-1:0] d, input logic rd);
    int p;
    logic [NR-1:0] mr;
    if (rs) begin
      m_init = 1; m_valid = 0; m_out = 0; m_idx = 0;
      m_last = NR - 1; m_cnt = 0;
    end else if (!m_valid) begin
      p = pick(rq, m_last);
      if (p >= 0) begin
        m_valid = 1; m_idx = p; m_out = slot(d, p);
      end
    end else if (rd) begin
      m_last = m_idx;
      m_cnt = (m_cnt + 1) % 65536;
      mr = rq;
      mr[m_idx] = 1'b0;
      p = pick(mr, m_idx);
      if (p >= 0) begin
        m_idx = p; m_out = slot(d, p);
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic step(input logic rs, input logic [NR-1:0] rq,
                      input logic [SZ*NR-1:0] d, input logic rd);
    int e_ack;
    reset = rs; req = rq; in = d; out_ready = rd;
    #1;
    c_out = int'(out); c_valid = int'(out_valid); c_idx = int'(grant_idx);
    c_cnt = int'(xfer_count); c_ack = int'(ack);
    if (m_init) begin
      e_ack = (m_valid && rd && !rs) ? (1 << m_idx) : 0;
      chk("m_valid", c_valid, int'(m_valid));
      chk("m_out", c_out, m_out);
      chk("m_idx", c_idx, m_idx);
      chk("m_cnt", c_cnt, m_cnt);
      chk("m_ack", c_ack, e_ack);
    end
    @(posedge clk);
    model_edge(rs, rq, d, rd);
    @(negedge clk);
  endtask

  function automatic logic [SZ*NR-1:0] rnd_in();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [SZ*NR-1:0] ramp();
    logic [SZ*NR-1:0] d;
    for (int i = 0; i < NR; i++) d[i*SZ +: SZ] = 8'(i * 8'h11);
    return d;
  endfunction

  initial begin
    logic [SZ*NR-1:0] d;
    reset = 1; req = '0; in = '0; out_ready = 0;
    @(negedge clk);

    // reset with random inputs
    step(1, 8'($urandom), rnd_in(), 1'($urandom));
    step(1, 8'($urandom), rnd_in(), 1'($urandom));
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_idx", int'(grant_idx), 0);
    chk("rst_cnt", int'(xfer_count), 0);
    chk("rst_ack", int'(ack), 0);

    // single request
    d = rnd_in();
    d[3*SZ +: SZ] = 8'h3C;
    step(0, 8'h08, d, 1);
    step(0, 8'h00, rnd_in(), 1);
    chk("single_out", c_out, 8'h3C);
    chk("single_idx", c_idx, 3);
    chk("single_ack", c_ack, 8'h08);
    chk("single_cnt", int'(xfer_count), 1);

    // full rotation
    step(1, 8'h00, '0, 0);
    step(0, 8'hFF, ramp(), 1);
    for (int k = 0; k < 9; k++) begin
      step(0, 8'hFF, ramp(), 1);
      chk("rot_valid", c_valid, 1);
      chk("rot_idx", c_idx, k % NR);
    end
    step(1, 8'h00, '0, 0);

    // backpressure on slot 2
    d = ramp();
    step(0, 8'h04, d, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 8'($urandom), rnd_in(), 0);
      chk("bp_out", c_out, 8'h22);
      chk("bp_idx", c_idx, 2);
      chk("bp_ack", c_ack, 0);
    end
    step(0, 8'h00, rnd_in(), 1);
    chk("bp_release_ack", c_ack, 8'h04);

    // wrap priority after slot 7
    step(0, 8'h80, ramp(), 1);
    step(0, 8'h41, ramp(), 1);
    chk("wrap_ack7", c_ack, 8'h80);
    step(0, 8'h40, ramp(), 1);
    chk("wrap_idx0", c_idx, 0);
    step(0, 8'h00, ramp(), 1);
    chk("wrap_idx6", c_idx, 6);
    chk("wrap_out6", c_out, 8'h66);

    // reset while holding a word
    step(0, 8'h01, ramp(), 0);
    step(1, 8'h01, ramp(), 1);
    chk("midrst_ack", c_ack, 0);
    chk("midrst_valid", int'(out_valid), 0);
    step(0, 8'h06, ramp(), 1);
    step(0, 8'h04, ramp(), 1);
    chk("midrst_idx", c_idx, 1);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0), 8'($urandom), rnd_in(),
           ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
